// File: rtl/dll_pkg.sv
// Shared DLL receive/transmit definitions: sequence type, Ack/Nak
// type and the duplicate-window rule used by both Ack/Nak and replay logic.
package dll_pkg;

    localparam int SEQ_WIDTH = 12;

    typedef logic [SEQ_WIDTH-1:0] seq_t;

    typedef enum logic {
        ACK = 1'b0,
        NAK = 1'b1
    } acknak_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } acknak_fsm_t;

    localparam seq_t DUP_WINDOW = seq_t'(1 << (SEQ_WIDTH - 1));

    // Already-seen TLP: 1 <= (nrs - seq) mod 2^W <= 2^(W-1)
    function automatic logic seq_is_duplicate(input seq_t nrs, input seq_t seq);
        seq_t d;
        d = nrs - seq;
        return (d != '0) && (d <= DUP_WINDOW);
    endfunction

endpackage

// File: rtl/dll_acknak_timer.sv
// AckNak latency counter: counts while enabled, saturates at the
// programmed latency and reports expiry until cleared.
module dll_acknak_timer #(
    parameter int TIMER_WIDTH = 16,
    parameter int ACK_LATENCY = 255
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_clear,
    output logic o_expire
);

    localparam logic [TIMER_WIDTH-1:0] LP_LAT = TIMER_WIDTH'(ACK_LATENCY);

    logic [TIMER_WIDTH-1:0] r_count;

    assign o_expire = (r_count >= LP_LAT);

    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_start && !o_expire) begin
            r_count <= r_count + TIMER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/dll_acknak_scheduler.sv
// Receive-side Ack/Nak scheduler: classifies checked TLPs, tracks
// NEXT_RCV_SEQ / NAK_SCHEDULED and requests Ack/Nak DLLPs from TX.
module dll_acknak_scheduler #(
    parameter int SEQ_WIDTH   = 12,
    parameter int TIMER_WIDTH = 16,
    parameter int ACK_LATENCY = 255
) (
    input  logic                 clk,
    input  logic                 preset,
    input  logic                 DL_up,
    input  logic                 tlp_done_i,
    input  logic [SEQ_WIDTH-1:0] tlp_seq_i,
    input  logic                 tlp_lcrc_ok_i,
    output logic                 tlp_accept_o,
    output logic                 tlp_discard_o,
    output logic                 dllp_req_o,
    output logic                 dllp_is_nak_o,
    output logic [SEQ_WIDTH-1:0] dllp_seq_o,
    input  logic                 dllp_ack_i,
    output logic [SEQ_WIDTH-1:0] next_rcv_seq_o,
    output logic                 nak_scheduled_o
);

    import dll_pkg::*;

    logic w_rst;
    logic w_done;
    logic w_in_order;
    logic w_dup;
    logic w_accept;
    logic w_dup_hit;
    logic w_nak_evt;
    logic w_set_nak;
    logic w_ack_eligible;
    logic w_timer_run;
    logic w_timer_expire;
    logic w_issue;
    logic w_issue_nak;

    acknak_fsm_t r_state;
    acknak_fsm_t w_state_nxt;

    logic [SEQ_WIDTH-1:0] r_nrs;
    logic [SEQ_WIDTH-1:0] r_dllp_seq;
    acknak_t              r_dllp_type;
    logic                 r_nak_sched;
    logic                 r_nak_pending;
    logic                 r_ack_pending;
    logic                 r_force_ack;
    logic                 r_force_arm;
    logic                 r_accept;
    logic                 r_discard;

    // Link down behaves exactly like reset
    assign w_rst      = preset | ~DL_up;
    assign w_done     = tlp_done_i & DL_up;
    assign w_in_order = (tlp_seq_i == r_nrs);
    assign w_dup      = seq_is_duplicate(seq_t'(r_nrs), seq_t'(tlp_seq_i));
    assign w_accept   = w_done & tlp_lcrc_ok_i & w_in_order;
    assign w_dup_hit  = w_done & tlp_lcrc_ok_i & ~w_in_order & w_dup;
    assign w_nak_evt  = w_done & ~w_accept & ~w_dup_hit;
    assign w_set_nak  = w_nak_evt & ~r_nak_sched;

    // Forced Acks wait one extra cycle so a Nak right behind wins
    assign w_ack_eligible = r_ack_pending & (w_timer_expire | r_force_arm);
    assign w_timer_run    = r_ack_pending & (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_nak = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_nak_pending) begin
                    w_issue     = 1'b1;
                    w_issue_nak = 1'b1;
                    w_state_nxt = ST_REQ;
                end else if (w_ack_eligible) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dllp_ack_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state       <= ST_IDLE;
            r_nrs         <= '0;
            r_dllp_seq    <= '0;
            r_dllp_type   <= ACK;
            r_nak_sched   <= 1'b0;
            r_nak_pending <= 1'b0;
            r_ack_pending <= 1'b0;
            r_force_ack   <= 1'b0;
            r_force_arm   <= 1'b0;
            r_accept      <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_accept  <= w_accept;
            r_discard <= w_dup_hit | w_nak_evt;
            if (w_accept) begin
                r_nrs       <= r_nrs + SEQ_WIDTH'(1);
                r_nak_sched <= 1'b0;
            end else if (w_set_nak) begin
                r_nak_sched <= 1'b1;
            end
            // New events on the issue edge survive the clear
            r_nak_pending <= (r_nak_pending & ~w_issue_nak) | w_set_nak;
            r_ack_pending <= (r_ack_pending & ~w_issue) | w_accept | w_dup_hit;
            r_force_ack   <= (r_force_ack & ~w_issue) | w_dup_hit;
            r_force_arm   <= r_force_ack & ~w_issue;
            if (w_issue) begin
                r_dllp_seq  <= r_nrs - SEQ_WIDTH'(1);
                r_dllp_type <= w_issue_nak ? NAK : ACK;
            end
        end
    end

    dll_acknak_timer #(
        .TIMER_WIDTH (TIMER_WIDTH),
        .ACK_LATENCY (ACK_LATENCY)
    ) u_timer (
        .clk      (clk),
        .i_rst    (w_rst),
        .i_start  (w_timer_run),
        .i_clear  (w_issue),
        .o_expire (w_timer_expire)
    );

    assign tlp_accept_o    = r_accept;
    assign tlp_discard_o   = r_discard;
    assign dllp_req_o      = (r_state == ST_REQ);
    assign dllp_is_nak_o   = (r_dllp_type == NAK);
    assign dllp_seq_o      = r_dllp_seq;
    assign next_rcv_seq_o  = r_nrs;
    assign nak_scheduled_o = r_nak_sched;

endmodule

// File: tb/tb_dll_acknak_scheduler.sv
// Self-checking bench for dll_acknak_scheduler: expected DLLPs are queued
// as stimulus is driven and checked when the scheduler raises a request.
module tb_dll_acknak_scheduler;

    localparam int LAT = 8;

    logic        clk;
    logic        preset;
    logic        DL_up;
    logic        tlp_done_i;
    logic [11:0] tlp_seq_i;
    logic        tlp_lcrc_ok_i;
    logic        tlp_accept_o;
    logic        tlp_discard_o;
    logic        dllp_req_o;
    logic        dllp_is_nak_o;
    logic [11:0] dllp_seq_o;
    logic        dllp_ack_i;
    logic [11:0] next_rcv_seq_o;
    logic        nak_scheduled_o;

    int n_cmp;
    int n_err;
    int cyc;
    int req_cnt;
    int req_cyc;
    logic hold_ack;
    logic sb_skip;
    logic req_prev;
    logic [12:0] cur_req;
    logic [12:0] exp_q[$];

    dll_acknak_scheduler #(
        .SEQ_WIDTH   (12),
        .TIMER_WIDTH (16),
        .ACK_LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .preset          (preset),
        .DL_up           (DL_up),
        .tlp_done_i      (tlp_done_i),
        .tlp_seq_i       (tlp_seq_i),
        .tlp_lcrc_ok_i   (tlp_lcrc_ok_i),
        .tlp_accept_o    (tlp_accept_o),
        .tlp_discard_o   (tlp_discard_o),
        .dllp_req_o      (dllp_req_o),
        .dllp_is_nak_o   (dllp_is_nak_o),
        .dllp_seq_o      (dllp_seq_o),
        .dllp_ack_i      (dllp_ack_i),
        .next_rcv_seq_o  (next_rcv_seq_o),
        .nak_scheduled_o (nak_scheduled_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Request monitor / scoreboard and automatic TX acknowledge
    initial begin
        dllp_ack_i = 1'b0;
        req_prev   = 1'b0;
        cur_req    = '0;
        forever begin
            @(negedge clk);
            if (dllp_req_o) begin
                if (!req_prev) begin
                    req_cnt++;
                    req_cyc = cyc;
                    cur_req = {dllp_is_nak_o, dllp_seq_o};
                    if (!sb_skip) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL unexpected_dllp: got nak=%0b seq=%h, none expected",
                                     dllp_is_nak_o, dllp_seq_o);
                        end else if ({dllp_is_nak_o, dllp_seq_o} !== exp_q[0]) begin
                            n_err++;
                            $display("FAIL dllp_fields: got nak=%0b seq=%h expected nak=%0b seq=%h",
                                     dllp_is_nak_o, dllp_seq_o, exp_q[0][12], exp_q[0][11:0]);
                            void'(exp_q.pop_front());
                        end else begin
                            void'(exp_q.pop_front());
                        end
                    end
                end else begin
                    n_cmp++;
                    if ({dllp_is_nak_o, dllp_seq_o} !== cur_req) begin
                        n_err++;
                        $display("FAIL req_stable: got %h expected %h",
                                 {dllp_is_nak_o, dllp_seq_o}, cur_req);
                    end
                end
            end
            req_prev   = dllp_req_o;
            dllp_ack_i = dllp_req_o && !hold_ack;
        end
    end

    task automatic pulse(input logic [11:0] s, input logic ok,
                         output logic acc, output logic dis);
        tlp_done_i    = 1'b1;
        tlp_seq_i     = s;
        tlp_lcrc_ok_i = ok;
        @(negedge clk);
        acc        = tlp_accept_o;
        dis        = tlp_discard_o;
        tlp_done_i = 1'b0;
    endtask

    task automatic wait_req(input int target, input int budget, output logic got);
        int k;
        k = 0;
        while (req_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        got = (req_cnt >= target);
    endtask

    task automatic test_reset;
        preset = 1'b1;
        DL_up  = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dllp_req_o, dllp_is_nak_o, dllp_seq_o} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_dllp: got %h expected 0",
                     {dllp_req_o, dllp_is_nak_o, dllp_seq_o});
        end
        n_cmp++;
        if (next_rcv_seq_o !== 12'd0) begin
            n_err++;
            $display("FAIL reset_nrs: got %h expected 0", next_rcv_seq_o);
        end
        n_cmp++;
        if ({tlp_accept_o, tlp_discard_o, nak_scheduled_o} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000",
                     {tlp_accept_o, tlp_discard_o, nak_scheduled_o});
        end
        preset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_in_order;
        logic a, d, got;
        int c0, r0;
        r0 = req_cnt;
        c0 = cyc;
        exp_q.push_back({1'b0, 12'd2});
        for (int i = 0; i < 3; i++) begin
            pulse(12'(i), 1'b1, a, d);
            n_cmp++;
            if ({a, d} !== 2'b10) begin
                n_err++;
                $display("FAIL inorder_accept%0d: got %b expected 10", i, {a, d});
            end
        end
        n_cmp++;
        if (next_rcv_seq_o !== 12'd3) begin
            n_err++;
            $display("FAIL inorder_nrs: got %h expected 3", next_rcv_seq_o);
        end
        wait_req(r0 + 1, 40, got);
        n_cmp++;
        if (!got || req_cyc - c0 != LAT + 2) begin
            n_err++;
            $display("FAIL inorder_ack_time: got %0d expected %0d (seen=%0b)",
                     req_cyc - c0, LAT + 2, got);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (req_cnt !== r0 + 1) begin
            n_err++;
            $display("FAIL inorder_one_ack: got %0d expected %0d", req_cnt - r0, 1);
        end
    endtask

    task automatic test_nak;
        logic a, d, got;
        int c0;
        exp_q.push_back({1'b0, 12'd4});
        pulse(12'd3, 1'b1, a, d);
        pulse(12'd4, 1'b1, a, d);
        wait_req(req_cnt + 1, 40, got);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (next_rcv_seq_o !== 12'd5) begin
            n_err++;
            $display("FAIL nak_setup_nrs: got %h expected 5", next_rcv_seq_o);
        end
        exp_q.push_back({1'b1, 12'd4});
        c0 = cyc;
        pulse(12'd5, 1'b0, a, d);
        n_cmp++;
        if ({a, d, nak_scheduled_o} !== 3'b011) begin
            n_err++;
            $display("FAIL nak_bad_discard: got %b expected 011", {a, d, nak_scheduled_o});
        end
        wait_req(req_cnt + 1, 20, got);
        n_cmp++;
        if (!got || req_cyc - c0 != 2) begin
            n_err++;
            $display("FAIL nak_time: got %0d expected 2 (seen=%0b)", req_cyc - c0, got);
        end
        repeat (3) @(negedge clk);
        exp_q.push_back({1'b0, 12'd5});
        pulse(12'd5, 1'b1, a, d);
        n_cmp++;
        if ({a, d, nak_scheduled_o, next_rcv_seq_o} !== {3'b100, 12'd6}) begin
            n_err++;
            $display("FAIL nak_recover: got %b/%h expected 100/006",
                     {a, d, nak_scheduled_o}, next_rcv_seq_o);
        end
        wait_req(req_cnt + 1, 40, got);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_gap;
        logic a, d, got;
        int r0;
        r0 = req_cnt;
        exp_q.push_back({1'b1, 12'd5});
        for (int i = 0; i < 2; i++) begin
            pulse(12'd8, 1'b1, a, d);
            n_cmp++;
            if ({a, d} !== 2'b01) begin
                n_err++;
                $display("FAIL gap_discard%0d: got %b expected 01", i, {a, d});
            end
        end
        wait_req(r0 + 1, 20, got);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (req_cnt !== r0 + 1 || nak_scheduled_o !== 1'b1) begin
            n_err++;
            $display("FAIL gap_single_nak: got reqs=%0d sched=%0b expected 1/1",
                     req_cnt - r0, nak_scheduled_o);
        end
        exp_q.push_back({1'b0, 12'd6});
        pulse(12'd6, 1'b1, a, d);
        wait_req(r0 + 2, 40, got);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_dup_wrap;
        logic a, d, got;
        int c0, n_acc;
        preset = 1'b1;
        @(negedge clk);
        preset = 1'b0;
        exp_q.push_back({1'b0, 12'hFFF});
        c0 = cyc;
        pulse(12'hFFF, 1'b1, a, d);
        n_cmp++;
        if ({a, d, next_rcv_seq_o} !== {2'b01, 12'h000}) begin
            n_err++;
            $display("FAIL dup_discard: got %b/%h expected 01/000", {a, d}, next_rcv_seq_o);
        end
        wait_req(req_cnt + 1, 20, got);
        n_cmp++;
        if (!got || req_cyc - c0 > 3) begin
            n_err++;
            $display("FAIL dup_fast_ack: got %0d cycles expected <=3 (seen=%0b)",
                     req_cyc - c0, got);
        end
        repeat (3) @(negedge clk);
        sb_skip = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 4095; i++) begin
            pulse(12'(i), 1'b1, a, d);
            if (a) n_acc++;
        end
        repeat (40) @(negedge clk);
        sb_skip = 1'b0;
        n_cmp++;
        if (n_acc != 4095 || next_rcv_seq_o !== 12'hFFF) begin
            n_err++;
            $display("FAIL fill: got %0d/%h expected 4095/fff", n_acc, next_rcv_seq_o);
        end
        exp_q.push_back({1'b0, 12'hFFE});
        pulse(12'hFFF, 1'b1, a, d);
        n_cmp++;
        if ({a, d, next_rcv_seq_o} !== {2'b10, 12'h000}) begin
            n_err++;
            $display("FAIL wrap: got %b/%h expected 10/000", {a, d}, next_rcv_seq_o);
        end
        void'(exp_q.pop_back());
        exp_q.push_back({1'b0, 12'hFFF});
        wait_req(req_cnt + 1, 40, got);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stall;
        logic a, d, got;
        hold_ack = 1'b1;
        exp_q.push_back({1'b1, 12'hFFF});
        pulse(12'd0, 1'b0, a, d);
        wait_req(req_cnt + 1, 20, got);
        pulse(12'd0, 1'b1, a, d);
        pulse(12'd1, 1'b1, a, d);
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({dllp_req_o, dllp_is_nak_o, dllp_seq_o, next_rcv_seq_o} !==
            {2'b11, 12'hFFF, 12'd2}) begin
            n_err++;
            $display("FAIL stall_frozen: got %b/%h nrs=%h expected 11/fff nrs=002",
                     {dllp_req_o, dllp_is_nak_o}, dllp_seq_o, next_rcv_seq_o);
        end
        exp_q.push_back({1'b0, 12'd1});
        hold_ack = 1'b0;
        wait_req(req_cnt + 1, 40, got);
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL stall_ack_after: got none expected ack seq 001");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_dlup;
        logic a, d, got;
        int r0;
        hold_ack = 1'b1;
        exp_q.push_back({1'b0, 12'd8});
        for (int i = 2; i < 9; i++) pulse(12'(i), 1'b1, a, d);
        wait_req(req_cnt + 1, 30, got);
        n_cmp++;
        if (!dllp_req_o || next_rcv_seq_o !== 12'd9) begin
            n_err++;
            $display("FAIL dlup_setup: got req=%0b nrs=%h expected 1/009",
                     dllp_req_o, next_rcv_seq_o);
        end
        DL_up = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({dllp_req_o, nak_scheduled_o, next_rcv_seq_o} !== 14'd0) begin
            n_err++;
            $display("FAIL dlup_drop: got req=%0b sched=%0b nrs=%h expected 0/0/000",
                     dllp_req_o, nak_scheduled_o, next_rcv_seq_o);
        end
        pulse(12'd0, 1'b1, a, d);
        pulse(12'd5, 1'b0, a, d);
        @(negedge clk);
        n_cmp++;
        if ({tlp_accept_o, tlp_discard_o, a, d} !== 4'b0000) begin
            n_err++;
            $display("FAIL dlup_ignore: got %b expected 0000",
                     {tlp_accept_o, tlp_discard_o, a, d});
        end
        hold_ack = 1'b0;
        DL_up    = 1'b1;
        r0 = req_cnt;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (req_cnt !== r0 || next_rcv_seq_o !== 12'd0) begin
            n_err++;
            $display("FAIL dlup_quiet: got reqs=%0d nrs=%h expected 0/000",
                     req_cnt - r0, next_rcv_seq_o);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        req_cnt       = 0;
        req_cyc       = 0;
        hold_ack      = 1'b0;
        sb_skip       = 1'b0;
        preset        = 1'b1;
        DL_up         = 1'b1;
        tlp_done_i    = 1'b0;
        tlp_seq_i     = '0;
        tlp_lcrc_ok_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_in_order();
        test_nak();
        test_gap();
        test_dup_wrap();
        test_stall();
        test_dlup();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
